// File: rtl/matmult_param.sv
// Parametrised NxN integer matrix multiplier (C = A*B or C = A*B + C_prev) with one
// sequential MAC, 4-phase load/unload handshakes, optional saturation and sticky overflow.
module matmult_param #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              i_ready,
    input  logic              o_got,
    input  logic              acc_mode,
    output logic [OUT_W-1:0]  r,
    output logic              out_ready,
    output logic              gotit,
    output logic              rdy,
    output logic              busy,
    output logic              ovf
);
    localparam int ACC_W = 2*DATA_W + $clog2(N) + 1;
    localparam int NN    = N*N;
    localparam int EW    = $clog2(NN);
    localparam int IW    = $clog2(N+1);
    localparam logic [EW-1:0] E_LAST = EW'(NN-1);
    localparam logic [IW-1:0] K_STORE = IW'(N);
    localparam logic [IW-1:0] I_LAST = IW'(N-1);

    typedef enum logic [2:0] {LD_WAIT, LD_ACK, COMP, UL_SHOW, UL_ACK} state_t;

    state_t            state;
    logic [EW-1:0]     e;
    logic [IW-1:0]     ci, cj, ck;
    logic [ACC_W-1:0]  acc;
    logic              acc_lat;
    logic [DATA_W-1:0] a_m [NN];
    logic [DATA_W-1:0] b_m [NN];
    logic [OUT_W-1:0]  c_m [NN];

    logic [IW-1:0]     ckc;
    logic [EW-1:0]     a_idx, b_idx, c_idx, e_nxt;
    logic [ACC_W-1:0]  prod, init, hi_s, hi_u;
    logic              out_of_range;
    logic [OUT_W-1:0]  store_val, clip_val;

    function automatic logic [ACC_W-1:0] ext_d(input logic [DATA_W-1:0] v);
        logic [ACC_W-1:0] m;
        m = '1;
        m = m << DATA_W;
        ext_d = ACC_W'(v) | ((SIGNED != 0 && v[DATA_W-1]) ? m : '0);
    endfunction

    function automatic logic [ACC_W-1:0] ext_o(input logic [OUT_W-1:0] v);
        logic [ACC_W-1:0] m;
        m = '1;
        m = m << OUT_W;
        ext_o = ACC_W'(v) | ((SIGNED != 0 && v[OUT_W-1]) ? m : '0);
    endfunction

    always_comb begin
        // k is clamped in the store cycle so the operand reads stay in range
        ckc   = (ck == K_STORE) ? '0 : ck;
        a_idx = EW'(int'(ci) * N + int'(ckc));
        b_idx = EW'(int'(ckc) * N + int'(cj));
        c_idx = EW'(int'(ci) * N + int'(cj));
        e_nxt = e + 1'b1;
        prod  = ext_d(a_m[a_idx]) * ext_d(b_m[b_idx]);
        init  = acc_lat ? ext_o(c_m[c_idx]) : '0;
        hi_s  = $signed(acc) >>> (OUT_W-1);
        hi_u  = acc >> OUT_W;
        if (SIGNED != 0) begin
            out_of_range = !((hi_s == '0) || (hi_s == '1));
            clip_val     = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            out_of_range = (hi_u != '0);
            clip_val     = '1;
        end
        store_val = (SAT != 0 && out_of_range) ? clip_val : acc[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LD_WAIT;
            e         <= '0;
            rdy       <= 1'b1;
            gotit     <= 1'b0;
            out_ready <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            r         <= '0;
            acc_lat   <= 1'b0;
            acc       <= '0;
            ci        <= '0;
            cj        <= '0;
            ck        <= '0;
            for (int x = 0; x < NN; x++) c_m[x] <= '0;
        end else begin
            case (state)
                LD_WAIT: if (i_ready) begin
                    a_m[e] <= a;
                    b_m[e] <= b;
                    rdy    <= 1'b0;
                    gotit  <= 1'b1;
                    state  <= LD_ACK;
                    if (e == '0) begin
                        acc_lat <= acc_mode;
                        ovf     <= 1'b0;
                    end
                end
                LD_ACK: if (!i_ready) begin
                    gotit <= 1'b0;
                    if (e == E_LAST) begin
                        e     <= '0;
                        busy  <= 1'b1;
                        ci    <= '0;
                        cj    <= '0;
                        ck    <= '0;
                        state <= COMP;
                    end else begin
                        e     <= e_nxt;
                        rdy   <= 1'b1;
                        state <= LD_WAIT;
                    end
                end
                COMP: begin
                    if (ck != K_STORE) begin
                        // The first MAC cycle folds in the initial value, giving N+1 cycles per element
                        acc <= ((ck == '0) ? init : acc) + prod;
                        ck  <= ck + 1'b1;
                    end else begin
                        c_m[c_idx] <= store_val;
                        if (out_of_range) ovf <= 1'b1;
                        ck <= '0;
                        if (cj == I_LAST) begin
                            cj <= '0;
                            if (ci == I_LAST) begin
                                ci        <= '0;
                                busy      <= 1'b0;
                                e         <= '0;
                                r         <= c_m[0];
                                out_ready <= 1'b1;
                                state     <= UL_SHOW;
                            end else begin
                                ci <= ci + 1'b1;
                            end
                        end else begin
                            cj <= cj + 1'b1;
                        end
                    end
                end
                UL_SHOW: if (o_got) begin
                    out_ready <= 1'b0;
                    gotit     <= 1'b1;
                    state     <= UL_ACK;
                end
                UL_ACK: if (!o_got) begin
                    gotit <= 1'b0;
                    if (e == E_LAST) begin
                        e     <= '0;
                        rdy   <= 1'b1;
                        state <= LD_WAIT;
                    end else begin
                        e         <= e_nxt;
                        r         <= c_m[e_nxt];
                        out_ready <= 1'b1;
                        state     <= UL_SHOW;
                    end
                end
                default: state <= LD_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_matmult_param.sv
// Bench for matmult_param: three instances (wide signed/sat, 8-bit signed/sat, 8-bit
// unsigned/wrap) driven in lockstep through directed load/compute/unload runs.
module tb_matmult_param;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        i_ready = 1'b0;
    logic        o_got = 1'b0;
    logic        acc_mode = 1'b0;

    logic [31:0] r_w;
    logic [7:0]  r_s, r_u;
    logic        out_ready_w, gotit_w, rdy_w, busy_w, ovf_w;
    logic        out_ready_s, gotit_s, rdy_s, busy_s, ovf_s;
    logic        out_ready_u, gotit_u, rdy_u, busy_u, ovf_u;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    logic [15:0] am [16];
    logic [15:0] bm [16];
    logic [31:0] exp_w [$];
    logic [7:0]  exp_s [$];
    logic [7:0]  exp_u [$];

    always #5 clk = ~clk;

    matmult_param #(.N(4), .DATA_W(16), .OUT_W(32), .SIGNED(1), .SAT(1)) dut_w (
        .clk(clk), .rst(rst), .a(a), .b(b), .i_ready(i_ready), .o_got(o_got),
        .acc_mode(acc_mode), .r(r_w), .out_ready(out_ready_w), .gotit(gotit_w),
        .rdy(rdy_w), .busy(busy_w), .ovf(ovf_w));

    matmult_param #(.N(4), .DATA_W(8), .OUT_W(8), .SIGNED(1), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .a(a[7:0]), .b(b[7:0]), .i_ready(i_ready), .o_got(o_got),
        .acc_mode(acc_mode), .r(r_s), .out_ready(out_ready_s), .gotit(gotit_s),
        .rdy(rdy_s), .busy(busy_s), .ovf(ovf_s));

    matmult_param #(.N(4), .DATA_W(8), .OUT_W(8), .SIGNED(0), .SAT(0)) dut_u (
        .clk(clk), .rst(rst), .a(a[7:0]), .b(b[7:0]), .i_ready(i_ready), .o_got(o_got),
        .acc_mode(acc_mode), .r(r_u), .out_ready(out_ready_u), .gotit(gotit_u),
        .rdy(rdy_u), .busy(busy_u), .ovf(ovf_u));

    always @(negedge clk) if (busy_w === 1'b1) busy_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       sig = rdy_w;
            1:       sig = gotit_w;
            2:       sig = out_ready_w;
            default: sig = busy_w;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val, input string tag);
        int n = 0;
        while (sig(sel) !== val && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic load_pair(input int idx);
        wait_sig(0, 1'b1, "rdy");
        a = am[idx];
        b = bm[idx];
        i_ready = 1'b1;
        @(negedge clk);
        wait_sig(1, 1'b1, "ld_gotit_hi");
        repeat ($urandom_range(0, 2)) @(negedge clk);
        i_ready = 1'b0;
        @(negedge clk);
        wait_sig(1, 1'b0, "ld_gotit_lo");
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic load_all(input logic accm, input int first);
        acc_mode = accm;
        for (int i = first; i < 16; i++) load_pair(i);
    endtask

    task automatic unload_all(input string tag);
        logic [31:0] ew, es, eu;
        for (int i = 0; i < 16; i++) begin
            wait_sig(2, 1'b1, "out_ready");
            if (exp_w.size() == 0 || exp_s.size() == 0 || exp_u.size() == 0) begin
                check({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                ew = exp_w.pop_front();
                es = 32'(exp_s.pop_front());
                eu = 32'(exp_u.pop_front());
                check({tag, "_r_w"}, r_w, ew);
                check({tag, "_r_s"}, 32'(r_s), es);
                check({tag, "_r_u"}, 32'(r_u), eu);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            o_got = 1'b1;
            @(negedge clk);
            wait_sig(1, 1'b1, "ul_gotit_hi");
            o_got = 1'b0;
            @(negedge clk);
            wait_sig(1, 1'b0, "ul_gotit_lo");
        end
        check({tag, "_sb_drained"}, 32'(exp_w.size() + exp_s.size() + exp_u.size()), 32'd0);
    endtask

    task automatic check_ovf(input string tag, input logic w, input logic s, input logic u);
        check({tag, "_ovf_w"}, 32'(ovf_w), 32'(w));
        check({tag, "_ovf_s"}, 32'(ovf_s), 32'(s));
        check({tag, "_ovf_u"}, 32'(ovf_u), 32'(u));
    endtask

    task automatic set_t1;
        for (int i = 0; i < 16; i++) begin
            am[i] = (i / 4 == i % 4) ? 16'd1 : 16'd0;
            bm[i] = 16'(i + 1);
        end
    endtask

    task automatic push_seq(input int scale);
        for (int i = 0; i < 16; i++) begin
            exp_w.push_back(32'((i + 1) * scale));
            exp_s.push_back(8'((i + 1) * scale));
            exp_u.push_back(8'((i + 1) * scale));
        end
    endtask

    task automatic push_const(input logic [31:0] w, input logic [7:0] s, input logic [7:0] u);
        for (int i = 0; i < 16; i++) begin
            exp_w.push_back(w);
            exp_s.push_back(s);
            exp_u.push_back(u);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rdy", 32'(rdy_w), 32'd1);
        check("rst_gotit", 32'(gotit_w), 32'd0);
        check("rst_out_ready", 32'(out_ready_w), 32'd0);
        check("rst_busy", 32'(busy_w), 32'd0);
        check("rst_ovf", 32'(ovf_w), 32'd0);
        check("rst_r", r_w, 32'd0);

        // T1: identity times 1..16
        set_t1();
        push_seq(1);
        busy_cnt = 0;
        load_all(1'b0, 0);
        unload_all("t1");
        check("t1_busy_cycles", 32'(busy_cnt), 32'd80);
        check_ovf("t1", 1'b0, 1'b0, 1'b0);

        // T2: accumulate onto previous result
        push_seq(2);
        load_all(1'b1, 0);
        unload_all("t2");
        check_ovf("t2", 1'b0, 1'b0, 1'b0);

        // T3: all -1 times all 3
        for (int i = 0; i < 16; i++) begin
            am[i] = 16'hFFFF;
            bm[i] = 16'd3;
        end
        push_const(32'hFFFF_FFF4, 8'hF4, 8'hF4);
        load_all(1'b0, 0);
        unload_all("t3");
        check_ovf("t3", 1'b0, 1'b0, 1'b1);

        // T4: 127*127*4 = 64516, saturates or wraps in 8 bits
        for (int i = 0; i < 16; i++) begin
            am[i] = 16'd127;
            bm[i] = 16'd127;
        end
        push_const(32'd64516, 8'h7F, 8'h04);
        load_all(1'b0, 0);
        unload_all("t4");
        check_ovf("t4", 1'b0, 1'b1, 1'b1);

        // T5: element 0 held for 10 cycles
        set_t1();
        push_seq(1);
        acc_mode = 1'b0;
        wait_sig(0, 1'b1, "t5_rdy");
        a = am[0];
        b = bm[0];
        i_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_gotit_held", 32'(gotit_w), 32'd1);
        check("t5_rdy_low", 32'(rdy_w), 32'd0);
        check("t5_ovf_cleared_s", 32'(ovf_s), 32'd0);
        i_ready = 1'b0;
        @(negedge clk);
        check("t5_gotit_drop", 32'(gotit_w), 32'd0);
        check("t5_rdy_back", 32'(rdy_w), 32'd1);
        load_all(1'b0, 1);
        unload_all("t5");
        check_ovf("t5", 1'b0, 1'b0, 1'b0);

        // T6: reset mid-compute clears C, then accumulate run equals plain product
        load_all(1'b1, 0);
        repeat (30) @(negedge clk);
        check("t6_busy_before", 32'(busy_w), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t6_busy", 32'(busy_w), 32'd0);
        check("t6_rdy", 32'(rdy_w), 32'd1);
        check("t6_out_ready", 32'(out_ready_w), 32'd0);
        check("t6_r", r_w, 32'd0);
        push_seq(1);
        load_all(1'b1, 0);
        unload_all("t6");
        check_ovf("t6", 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
